// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
// Mult/div run for a fixed parameterised latency; MTHI/MTLO complete in one edge.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [2:0]    op_q;

  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] prod_u;
  logic           a_neg;
  logic           b_neg;
  logic           div_zero;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W-1:0]   q_mag;
  logic [W-1:0]   r_mag;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;

  // Result datapath: one shared magnitude divider; signs restored for DIV so the
  // remainder follows the dividend and 0x80000000/-1 wraps to 0x80000000.
  always_comb begin
    prod_s   = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
    prod_u   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    a_neg    = (op_q == OP_DIV) && a_q[W-1];
    b_neg    = (op_q == OP_DIV) && b_q[W-1];
    div_zero = (b_q == '0);
    a_mag    = a_neg ? W'(-a_q) : a_q;
    b_mag    = b_neg ? W'(-b_q) : b_q;
    q_mag    = div_zero ? '0 : a_mag / b_mag;
    r_mag    = div_zero ? '0 : a_mag % b_mag;
    quot     = (a_neg ^ b_neg) ? W'(-q_mag) : q_mag;
    rem      = a_neg ? W'(-r_mag) : r_mag;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_MULT;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                cnt   <= CW'(MULT_CYCLES);
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                cnt   <= CW'(DIV_CYCLES);
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored here; HI/LO change only on the final edge
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            case (op_q)
              OP_MULT: begin
                HI <= prod_s[2*W-1:W];
                LO <= prod_s[W-1:0];
              end
              OP_MULTU: begin
                HI <= prod_u[2*W-1:W];
                LO <= prod_u[W-1:0];
              end
              OP_DIV, OP_DIVU: begin
                if (!div_zero) begin
                  HI <= rem;
                  LO <= quot;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: driver pushes expected HI/LO/latency from a
// longint-arithmetic reference model; a negedge monitor checks each completion.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        CLK;
  logic        RESET;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_checks;
  int          n_fail;
  int          abort_cnt;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin t = sa * sb; hi = t[63:32]; lo = t[31:0]; end
      3'd1: begin t = ua * ub; hi = t[63:32]; lo = t[31:0]; end
      3'd2: if (b != 0) begin
        sq = sa / sb; sr = sa % sb;
        t = sq; lo = t[31:0];
        t = sr; hi = t[31:0];
      end
      3'd3: if (b != 0) begin
        t = ua / ub; lo = t[31:0];
        t = ua % ub; hi = t[31:0];
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endtask

  task automatic push_exp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model_op(o, a, b, m_hi, m_lo);
    e.hi = m_hi;
    e.lo = m_lo;
    e.cycles = (o < 3'd2) ? MC : DC;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles", busy, k);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    start = 1'b1; op = o; A = a; B = b;
    if (o <= 3'd3) push_exp(o, a, b);
    else model_op(o, a, b, m_hi, m_lo);
    @(negedge CLK);
    start = 1'b0; A = $urandom; B = $urandom;
    if (o <= 3'd3) begin
      wait_idle();
    end else begin
      check("busy_single", {31'b0, busy}, 32'd0);
      check("hi_single", HI, m_hi);
      check("lo_single", LO, m_lo);
    end
  endtask

  // Monitor: a busy fall marks a completion; latency is the count of busy samples
  initial begin
    int   cyc = 0;
    int   seen_abort = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (busy === 1'b1) begin
        cyc++;
      end else if (prev) begin
        if (abort_cnt > seen_abort) begin
          seen_abort++;
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: HI=0x%08h LO=0x%08h", HI, LO);
        end else begin
          e = exp_q.pop_front();
          check("hi", HI, e.hi);
          check("lo", LO, e.lo);
          check("latency", 32'(cyc), 32'(e.cycles));
        end
        cyc = 0;
      end
      prev = (busy === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    n_checks = 0; n_fail = 0; abort_cnt = 0;
    m_hi = '0; m_lo = '0;
    RESET = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    #8 RESET = 1'b0;

    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    issue(3'd1, 32'hFFFFFFFD, 32'd5);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    issue(3'd3, 32'd7, 32'd2);
    issue(3'd4, 32'h12345678, 32'd0);
    issue(3'd5, 32'h9ABCDEF0, 32'd0);
    issue(3'd2, 32'h00000064, 32'd0);
    issue(3'd3, 32'hFFFFFFFF, 32'd0);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    issue(3'd6, 32'h55555555, 32'd1);
    issue(3'd7, 32'hAAAAAAAA, 32'd1);

    // Starts during RUN (including MTLO) and operand changes are ignored
    @(negedge CLK);
    start = 1'b1; op = 3'd0; A = 32'd2; B = 32'd3;
    push_exp(3'd0, 32'd2, 32'd3);
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    start = 1'b1; op = 3'd5; A = 32'hDEADBEEF; B = 32'h11111111;
    @(negedge CLK);
    check("hold_hi_in_run", HI, 32'h00000000);
    check("hold_lo_in_run", LO, 32'h80000000);
    @(negedge CLK);
    start = 1'b0;
    wait_idle();

    // start held high: second MULT accepted only one edge after completion
    @(negedge CLK);
    start = 1'b1; op = 3'd0; A = 32'd11; B = 32'hFFFFFFF0;
    push_exp(3'd0, 32'd11, 32'hFFFFFFF0);
    @(negedge CLK);
    A = 32'd13;
    push_exp(3'd0, 32'd13, 32'hFFFFFFF0);
    wait_idle();
    @(negedge CLK);
    start = 1'b0;
    check("b2b_rebusy", {31'b0, busy}, 32'd1);
    wait_idle();

    // Asynchronous reset while idle with HI/LO non-zero
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("arst_idle_busy", {31'b0, busy}, 32'd0);
    check("arst_idle_hi", HI, 32'd0);
    check("arst_idle_lo", LO, 32'd0);
    #1 RESET = 1'b0;
    m_hi = '0; m_lo = '0;

    // Reset mid-MULT: no write at the original completion edge
    issue(3'd4, 32'hCAFEF00D, 32'd0);
    @(negedge CLK);
    start = 1'b1; op = 3'd0; A = 32'd7; B = 32'd9;
    push_exp(3'd0, 32'd7, 32'd9);
    @(negedge CLK);
    start = 1'b0;
    @(posedge CLK);
    #2 RESET = 1'b1;
    void'(exp_q.pop_back());
    abort_cnt++;
    #1;
    check("arst_run_busy", {31'b0, busy}, 32'd0);
    check("arst_run_hi", HI, 32'd0);
    check("arst_run_lo", LO, 32'd0);
    #1 RESET = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (MC + 3) @(negedge CLK);
    check("post_abort_busy", {31'b0, busy}, 32'd0);
    check("post_abort_hi", HI, 32'd0);
    check("post_abort_lo", LO, 32'd0);

    // Randomized mix, biased toward divide corner cases
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 9)); end
        3: begin a = -32'($urandom_range(1, 40)); b = 32'($urandom_range(1, 9)); end
        default: ;
      endcase
      issue(o, a, b);
    end

    repeat (3) @(negedge CLK);
    check("pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
